fetch_ctrl: RTL and testbench

Sequences instruction fetch from the single-cycle combinational instruction memory (`instr_mem`-style: `pc` in, `inst` out same cycle) and presents one registered instruction at a time to decode over a valid/ready handshake. Owns the program counter and accepts branch redirects from execute. Detects `HALT` and can be restarted without reset. Flags out-of-range PCs. Sits between the instruction memory and the decode stage of the core.

---
 rtl/fetch_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch sequencer. Owns the program counter, reads a single-cycle
// combinational instruction memory (pc out, mem_inst back in the same cycle),
// and hands one registered instruction at a time to decode. It accepts branch
// redirects from execute, stops on a HALT opcode and can be restarted without
// reset, and traps permanently (until reset) on a fetch from an out-of-range PC.
//
// Parameters
//   WIDTH      instruction width (opcode is the top 5 bits, WIDTH >= 5)
//   MEM_DEPTH  number of valid instruction words; legal PCs are 0..MEM_DEPTH-1
//   RESET_PC   PC loaded on reset and on start
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   begin fetching from RESET_PC (IDLE and HALTED only)
//   pc             out  address to the instruction memory
//   mem_inst       in   instruction memory read data for pc, same cycle
//   inst_out       out  registered instruction to decode
//   inst_pc        out  address inst_out was fetched from
//   inst_valid     out  inst_out holds an undelivered instruction
//   inst_ready     in   decode accepts
//   redirect_valid in   execute requests a PC change (one-cycle pulse)
//   redirect_pc    in   redirect target
//   halted         out  controller is in HALTED
//   fault          out  sticky: a fetch was attempted at pc >= MEM_DEPTH
//   fetch_count    out  instructions delivered since reset/start (wraps)
//   state_dbg      out  current FSM state: 0 IDLE, 1 FETCH, 2 HALTED, 3 FAULT
//
// Handshake: an instruction transfers to decode on every rising edge where
// inst_valid & inst_ready are both high. inst_valid never depends on
// inst_ready, and while inst_valid & !inst_ready holds, inst_out and inst_pc
// are held stable until the transfer or a flush (redirect, start, reset).
// -----------------------------------------------------------------------------

`ifndef WIDTH
`define WIDTH 16
`endif

`ifndef HALT
`define HALT 5'b11111
`endif

module fetch_ctrl #(
  parameter int unsigned WIDTH     = `WIDTH,
  parameter int unsigned MEM_DEPTH = 16,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [31:0]      pc,
  input  logic [WIDTH-1:0] mem_inst,
  output logic [WIDTH-1:0] inst_out,
  output logic [31:0]      inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fetch_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [31:0]      count_q, count_d;

  logic             handshake;
  logic             slot_free;
  logic             pc_out_of_range;
  logic             is_halt;

  assign handshake       = valid_q & inst_ready;
  // The output register can take a new word if it is empty or being drained
  // in this very cycle.
  assign slot_free       = ~valid_q | inst_ready;
  assign pc_out_of_range = (pc_q >= MEM_DEPTH);
  assign is_halt         = (mem_inst[WIDTH-1 -: 5] == `HALT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    // A delivered word leaves the slot unless something reloads it below.
    valid_d   = valid_q & ~inst_ready;
    fault_d   = fault_q;
    // Deliveries are counted in every state, including the cycle of a redirect.
    count_d   = count_q + {31'd0, handshake};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          count_d = '0;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          // Flush whatever is queued for decode; the target is fetched on the
          // next cycle, which gives the single bubble after a redirect.
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (slot_free) begin
          if (pc_out_of_range) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            inst_d    = mem_inst;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            if (is_halt) begin
              // pc stays on the HALT word; nothing more is loaded.
              state_d = S_HALTED;
            end else begin
              pc_d = pc_q + 32'd1;
            end
          end
        end
      end

      S_HALTED: begin
        // The HALT word drains normally through the default valid_d above.
        if (start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          count_d = '0;
          valid_d = 1'b0;
        end
      end

      S_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc          = pc_q;
  assign inst_out    = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = valid_q;
  assign halted      = (state_q == S_HALTED);
  assign fault       = fault_q;
  assign fetch_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Bench for fetch_ctrl. The instruction memory is an array in the bench. For
// each program run the expected delivery stream (pc, word) is derived from the
// program shape: straight line 0..src, the loop dst..src repeated k times
// (execute redirects to dst each time src is delivered), then src+1..HALT.
// A negedge monitor pops that stream on every handshake.
// -----------------------------------------------------------------------------

`ifndef WIDTH
`define WIDTH 16
`endif

`ifndef HALT
`define HALT 5'b11111
`endif

module tb_fetch_ctrl;

  localparam int          W     = 16;
  localparam int          DEPTH = 16;
  localparam logic [31:0] RPC   = 32'd0;
  localparam int          EW    = 32 + W;

  localparam logic [4:0] OP_MOV = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h02;
  localparam logic [4:0] OP_MPY = 5'h03;
  localparam logic [4:0] OP_CMP = 5'h04;
  localparam logic [4:0] OP_BR  = 5'h05;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   pc;
  logic [W-1:0]  mem_inst;
  logic [W-1:0]  inst_out;
  logic [31:0]   inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          halted;
  logic          fault;
  logic [31:0]   fetch_count;
  logic [1:0]    state_dbg;

  logic [W-1:0]  mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_inst = (pc < DEPTH) ? mem[pc[3:0]] : '0;

  fetch_ctrl #(
    .WIDTH     (W),
    .MEM_DEPTH (DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pc             (pc),
    .mem_inst       (mem_inst),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count),
    .state_dbg      (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int            n_checks = 0;
  int            n_fail   = 0;

  int            bubble_stage = 0;
  logic [31:0]   bubble_pc    = '0;
  logic          prev_stall   = 1'b0;
  logic [W-1:0]  prev_out     = '0;
  logic [31:0]   prev_pc      = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int p);
    exp_q.push_back({32'(p), mem[p]});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares deliveries, back-pressure stability and redirect bubbles
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      bubble_stage = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {63'd0, inst_valid}, 64'd1);
        check("stall_inst", {48'd0, inst_out}, {48'd0, prev_out});
        check("stall_pc", {32'd0, inst_pc}, {32'd0, prev_pc});
      end
      if (bubble_stage == 3) begin
        bubble_stage = 2;
      end else if (bubble_stage == 2) begin
        check("bubble_gap", {63'd0, inst_valid}, 64'd0);
        bubble_stage = 1;
      end else if (bubble_stage == 1) begin
        check("bubble_target", {31'd0, inst_valid, inst_pc}, {31'd0, 1'b1, bubble_pc});
        bubble_stage = 0;
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_delivery: got pc %0d, expected no delivery", inst_pc);
        end else begin
          exp_e = exp_q.pop_front();
          check("deliver_pc", {32'd0, inst_pc}, {32'd0, exp_e[EW-1:W]});
          check("deliver_inst", {48'd0, inst_out}, {48'd0, exp_e[W-1:0]});
        end
      end
      prev_stall = inst_valid && !inst_ready;
      prev_out   = inst_out;
      prev_pc    = inst_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, {32'd0, pc}, {32'd0, RPC});
    check({tag, "_inst_out"}, {48'd0, inst_out}, 64'd0);
    check({tag, "_inst_pc"}, {32'd0, inst_pc}, 64'd0);
    check({tag, "_valid"}, {63'd0, inst_valid}, 64'd0);
    check({tag, "_halted"}, {63'd0, halted}, 64'd0);
    check({tag, "_fault"}, {63'd0, fault}, 64'd0);
    check({tag, "_count"}, {32'd0, fetch_count}, 64'd0);
    check({tag, "_state"}, {62'd0, state_dbg}, 64'd0);
  endtask

  task automatic load_directed();
    logic [4:0] ops [8];
    ops = '{OP_MOV, OP_MOV, OP_MOV, OP_MPY, OP_ADD, OP_CMP, OP_BR, `HALT};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = W'($urandom);
      mem[i][W-1 -: 5] = ops[i];
    end
  endtask

  // Random non-HALT words everywhere, HALT at len-1.
  task automatic load_random(input int len);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = W'($urandom);
      mem[i][W-1 -: 5] = 5'($urandom_range(0, 30));
    end
    mem[len-1][W-1 -: 5] = `HALT;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start          = 1'b1;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
  endtask

  // Runs the loaded program from start to the delivery of HALT.
  task automatic run_program(input int len, input int src, input int dst,
                             input int k, input bit rnd_ready);
    int          bubbles = 0;
    int          left    = k;
    bit          hseen   = 1'b0;
    bit          done    = 1'b0;
    logic [31:0] exp_count;
    for (int p = 0; p <= src; p++) push_exp(p);
    for (int r = 0; r < k; r++)
      for (int p = dst; p <= src; p++) push_exp(p);
    for (int p = src + 1; p < len; p++) push_exp(p);
    exp_count = 32'(len + k * (src - dst + 1));

    pulse_start();
    check("start_pc", {32'd0, pc}, {32'd0, RPC});
    check("start_valid", {63'd0, inst_valid}, 64'd0);
    check("start_halted", {63'd0, halted}, 64'd0);
    check("start_count", {32'd0, fetch_count}, 64'd0);

    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      inst_ready     = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (cyc == 0)
        check("first_load", {31'd0, inst_valid, inst_pc}, {31'd0, 1'b1, RPC});
      if (halted && !hseen) begin
        hseen = 1'b1;
        check("halt_word", {26'd0, inst_valid, inst_pc, inst_out[W-1 -: 5]},
              {26'd0, 1'b1, 32'(len - 1), `HALT});
      end
      if (!inst_valid && !halted) bubbles++;
      if (inst_valid && inst_ready && inst_pc == 32'(src) && left > 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'(dst);
        left--;
        bubble_pc    = 32'(dst);
        bubble_stage = 3;
      end
      if (halted && exp_q.size() == 0 && !inst_valid) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: %0d deliveries outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    check("halt_count", {32'd0, fetch_count}, {32'd0, exp_count});
    check("bubbles", 64'(bubbles), 64'(k));
    check("halted_end", {63'd0, halted}, 64'd1);
    check("no_fault", {63'd0, fault}, 64'd0);
  endtask

  task automatic fault_test();
    bit found = 1'b0;
    load_random(12);
    for (int p = 0; p < 3; p++) push_exp(p);
    pulse_start();
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      #1;
      if (inst_valid && inst_pc == 32'd2) begin
        found          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'(DEPTH);
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL fault_setup: got no delivery of pc 2, expected one");
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    check("fault_flush", {30'd0, inst_valid, fault, pc}, {30'd0, 1'b0, 1'b0, 32'(DEPTH)});
    @(posedge clk); #2;
    check("fault_set", {61'd0, fault, inst_valid, halted}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("fault_state", {62'd0, state_dbg}, 64'd3);
    @(posedge clk); #1;
    start          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    @(posedge clk); #1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("fault_sticky", {62'd0, fault, inst_valid}, {62'd0, 1'b1, 1'b0});
    check("fault_pc_held", {32'd0, pc}, 64'(DEPTH));
    check("fault_count", {32'd0, fetch_count}, 64'd3);
    check("fault_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_midstream();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    load_directed();
    pulse_start();
    inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_valid", {31'd0, inst_valid, inst_pc}, {31'd0, 1'b1, 32'd0});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd5;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    check_reset_outputs("idle_after_rst");
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    int len, src, dst, k;
    rst_n          = 1'b0;
    start          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    #12;
    check_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    load_directed();
    run_program(8, 6, 3, 0, 1'b0);
    run_program(8, 6, 3, 5, 1'b0);

    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(4, 12);
      src = $urandom_range(1, len - 2);
      dst = $urandom_range(0, src);
      k   = $urandom_range(0, 3);
      load_random(len);
      run_program(len, src, dst, k, 1'b1);
    end

    fault_test();
    reset_midstream();

    load_directed();
    run_program(8, 6, 3, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
